alu_cmd_sequencer: RTL

Upstream feeder for the 4-bit registered ALU stage. It buffers operand/opcode commands in a small FIFO and issues them one at a time on the ALU's a/b/opcode inputs. It captures the ALU's registered result, carry and overflow at the correct cycle, then presents them on a valid/ready response port. The ALU's one-cycle result latency is hidden from the command source.

---
 rtl/alu_cmd_sequencer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: queues ALU commands and issues them one at a time to a 1-cycle registered ALU.
// Latency: legal op responds 3 cycles after acceptance into an idle, empty block; illegal op responds after 1.
// Backpressure: cmd_ready drops while the FIFO is full; rsp_* are held until rsp_ready.
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  input  logic [3:0]       cmd_op,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [3:0]       alu_op,
  input  logic [7:0]       alu_result,
  input  logic             alu_carry,
  input  logic             alu_ovf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_result,
  output logic             rsp_carry,
  output logic             rsp_ovf,
  output logic             rsp_illegal,
  output logic [CNT_W-1:0] cmd_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [3:0]       fifo_a  [DEPTH];
  logic [3:0]       fifo_b  [DEPTH];
  logic [3:0]       fifo_op [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [1:0]       state;

  logic             push;
  logic             pop;
  logic [3:0]       head_a;
  logic [3:0]       head_b;
  logic [3:0]       head_op;
  logic             head_illegal;

  assign cmd_ready    = (count < DEPTH_C);
  assign push         = cmd_valid & cmd_ready;
  // Only IDLE pops, so at most one command is ever past the FIFO.
  assign pop          = (state == IDLE) && (count != '0);
  assign head_a       = fifo_a[rd_ptr];
  assign head_b       = fifo_b[rd_ptr];
  assign head_op      = fifo_op[rd_ptr];
  assign head_illegal = (head_op > 4'd8);
  assign cmd_count    = count;

  // Command storage; contents need no reset because reads are gated by count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a[wr_ptr]  <= cmd_a;
      fifo_b[wr_ptr]  <= cmd_b;
      fifo_op[wr_ptr] <= cmd_op;
    end
  end

  // FIFO pointers (wrap naturally, DEPTH is a power of two) and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sequencer: IDLE -> ISSUE -> WAIT -> RESP for legal ops, IDLE -> RESP for illegal ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (pop) state <= head_illegal ? RESP : ISSUE;
        ISSUE:   state <= WAIT;
        WAIT:    state <= RESP;
        RESP:    if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // ALU operand registers: loaded only when a legal command leaves the FIFO, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a  <= 4'h0;
      alu_b  <= 4'h0;
      alu_op <= 4'hF;
    end else if (pop && !head_illegal) begin
      alu_a  <= head_a;
      alu_b  <= head_b;
      alu_op <= head_op;
    end
  end

  // Response registers: captured from the ALU in WAIT (its result is for the issued command),
  // synthesised for illegal ops, and data left in place after the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid   <= 1'b0;
      rsp_result  <= 8'h00;
      rsp_carry   <= 1'b0;
      rsp_ovf     <= 1'b0;
      rsp_illegal <= 1'b0;
    end else begin
      if (pop && head_illegal) begin
        rsp_valid   <= 1'b1;
        rsp_result  <= 8'h00;
        rsp_carry   <= 1'b0;
        rsp_ovf     <= 1'b0;
        rsp_illegal <= 1'b1;
      end else if (state == WAIT) begin
        rsp_valid   <= 1'b1;
        rsp_result  <= alu_result;
        rsp_carry   <= alu_carry;
        rsp_ovf     <= alu_ovf;
        rsp_illegal <= 1'b0;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid   <= 1'b0;
      end
    end
  end

endmodule
